// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle instruction sequencer for the scalar RV32I core.
// Fetches over a req/ack handshake, classifies the opcode, then strobes
// register-file read, execute and register-file write one cycle at a time.
// Owns the PC and the retired-instruction counter; traps on unknown opcodes.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | parked, nothing asserted; leaves when HALT is low
// FETCH     | IMEM_REQ high at PC until IMEM_ACK; latches the instruction
// DECODE    | RF_RD_EN pulse; opcode classified, illegal goes to TRAPPED
// EXECUTE   | EX_VALID pulse; branch outcome/target captured on exit
// WRITEBACK | RF_WE pulse for write-class rd!=0; PC and RETIRED update on exit
// TRAPPED   | sticky TRAP, no strobes; only reset leaves
module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_halt,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic        o_rf_rd_en,
  output logic        o_ex_valid,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_pc,
  output logic [31:0] o_retired,
  output logic        o_trap,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAPPED   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_retired;
  logic        r_trap;
  logic        r_imem_req;
  logic        r_rf_rd_en;
  logic        r_ex_valid;
  logic        r_rf_we;
  logic        r_redirect;
  logic [31:0] r_br_target;

  logic [6:0]  w_opcode;
  logic        w_is_branch;
  logic        w_is_jal;
  logic        w_write_class;
  logic        w_illegal;

  // Opcode classification is a pure decode of the latched instruction.
  always_comb begin
    w_opcode      = r_inst[6:0];
    w_is_branch   = (w_opcode == OPC_BRANCH);
    w_is_jal      = (w_opcode == OPC_JAL);
    w_write_class = (w_opcode == OPC_OP_IMM) || (w_opcode == OPC_OP) ||
                    (w_opcode == OPC_LUI)    || w_is_jal;
    w_illegal     = !(w_write_class || w_is_branch);
  end

  // Sequencer: state, PC, counters and strobes are all registered here.
  // Strobes are cleared every cycle and set only on entry to their state,
  // which keeps them one-hot in time and exactly one cycle wide.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= 32'h0;
      r_retired   <= 32'h0;
      r_trap      <= 1'b0;
      r_imem_req  <= 1'b0;
      r_rf_rd_en  <= 1'b0;
      r_ex_valid  <= 1'b0;
      r_rf_we     <= 1'b0;
      r_redirect  <= 1'b0;
      r_br_target <= 32'h0;
    end else begin
      r_imem_req <= 1'b0;
      r_rf_rd_en <= 1'b0;
      r_ex_valid <= 1'b0;
      r_rf_we    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_halt) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (i_imem_ack) begin
            r_inst     <= i_imem_rdata;
            r_state    <= S_DECODE;
            r_rf_rd_en <= 1'b1;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          if (w_illegal) begin
            r_state <= S_TRAPPED;
            r_trap  <= 1'b1;
          end else begin
            r_state    <= S_EXECUTE;
            r_ex_valid <= 1'b1;
          end
        end
        S_EXECUTE: begin
          // JAL always redirects; a branch redirects only if taken.
          r_redirect  <= w_is_jal || (w_is_branch && i_br_taken);
          r_br_target <= i_br_target;
          r_rf_we     <= w_write_class && (r_inst[11:7] != 5'd0);
          r_state     <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          r_pc      <= r_redirect ? r_br_target : (r_pc + PC_STEP);
          r_retired <= r_retired + 32'd1;
          if (!i_halt) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_TRAPPED: begin
          r_trap <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_pc;
  assign o_inst      = r_inst;
  assign o_rf_rd_en  = r_rf_rd_en;
  assign o_ex_valid  = r_ex_valid;
  assign o_rf_we     = r_rf_we;
  assign o_rf_waddr  = r_inst[11:7];
  assign o_pc        = r_pc;
  assign o_retired   = r_retired;
  assign o_trap      = r_trap;
  assign o_state     = r_state;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: fetch timing, handshake stall, branch,
// JAL, halt, illegal-opcode trap and asynchronous reset recovery.
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        rf_rd_en;
  logic        ex_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        trap;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_seq_ctrl #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .i_clock(clk), .i_reset(rst), .i_halt(halt),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .o_inst(inst), .o_rf_rd_en(rf_rd_en), .o_ex_valid(ex_valid),
    .i_br_taken(br_taken), .i_br_target(br_target),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_pc(pc),
    .o_retired(retired), .o_trap(trap), .o_state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample on the falling edge; strobes must be one-hot.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("strobe_onehot", 32'($countones({imem_req, rf_rd_en, ex_valid, rf_we}) <= 1), 32'd1);
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    br_taken = 1'b0; br_target = 32'h0;
    @(negedge clk); @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);

    // Back-to-back addi x1,x0,1 with ack tied high.
    imem_ack = 1'b1; imem_rdata = 32'h0010_0093;
    rst = 1'b0;
    tick();
    check("f0_state", 32'(state), 32'd1);
    check("f0_req", 32'(imem_req), 32'd1);
    check("f0_addr", imem_addr, 32'h0);
    tick();
    check("d0_rd_en", 32'(rf_rd_en), 32'd1);
    check("d0_inst", inst, 32'h0010_0093);
    tick();
    check("e0_ex_valid", 32'(ex_valid), 32'd1);
    tick();
    check("w0_rf_we", 32'(rf_we), 32'd1);
    check("w0_waddr", 32'(rf_waddr), 32'd1);
    tick();
    check("f1_addr", imem_addr, 32'h4);
    check("f1_retired", retired, 32'd1);
    repeat (4) tick();
    check("f2_addr", imem_addr, 32'h8);
    repeat (4) tick();
    check("f3_addr", imem_addr, 32'hC);
    check("f3_retired", retired, 32'd3);

    // Ack withheld for three cycles at PC=0xC.
    imem_ack = 1'b0; imem_rdata = 32'h0020_0113;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", imem_addr, 32'hC);
      check("stall_inst", inst, 32'h0010_0093);
    end
    imem_ack = 1'b1;
    tick();
    check("ack_inst", inst, 32'h0020_0113);
    tick(); tick();
    check("ack_waddr", 32'(rf_waddr), 32'd2);
    check("ack_rf_we", 32'(rf_we), 32'd1);
    tick();
    check("ack_retired", retired, 32'd4);
    check("ack_addr", imem_addr, 32'h10);

    // Taken branch to 0x100; BR_TAKEN dropped after EXECUTE must not matter.
    imem_rdata = 32'h0000_0063;
    tick(); tick();
    br_taken = 1'b1; br_target = 32'h100;
    tick();
    check("bt_rf_we", 32'(rf_we), 32'd0);
    br_taken = 1'b0; br_target = 32'h0;
    tick();
    check("bt_addr", imem_addr, 32'h100);
    check("bt_retired", retired, 32'd5);

    // Not-taken branch falls through.
    br_target = 32'h200;
    tick(); tick(); tick();
    check("bn_rf_we", 32'(rf_we), 32'd0);
    tick();
    check("bn_addr", imem_addr, 32'h104);

    // JAL x0 with BR_TAKEN low: still jumps, no write.
    imem_rdata = 32'h0000_006F; br_target = 32'h40; br_taken = 1'b0;
    tick(); tick(); tick();
    check("jal_rf_we", 32'(rf_we), 32'd0);
    tick();
    check("jal_pc", pc, 32'h40);
    check("jal_retired", retired, 32'd7);

    // HALT raised during EXECUTE: writeback completes, then IDLE.
    imem_rdata = 32'h0010_0093;
    tick(); tick();
    check("h_exec", 32'(state), 32'd3);
    halt = 1'b1;
    tick();
    check("h_rf_we", 32'(rf_we), 32'd1);
    tick();
    check("h_state", 32'(state), 32'd0);
    check("h_pc", pc, 32'h44);
    check("h_retired", retired, 32'd8);
    tick();
    check("h_hold_state", 32'(state), 32'd0);
    check("h_hold_req", 32'(imem_req), 32'd0);
    halt = 1'b0;
    tick();
    check("h_resume_req", 32'(imem_req), 32'd1);
    check("h_resume_addr", imem_addr, 32'h44);

    // Illegal opcode traps; PC and RETIRED frozen.
    imem_rdata = 32'h0000_0000;
    tick(); tick();
    check("trap_flag", 32'(trap), 32'd1);
    check("trap_state", 32'(state), 32'd5);
    repeat (3) tick();
    check("trap_req", 32'(imem_req), 32'd0);
    check("trap_pc", pc, 32'h44);
    check("trap_retired", retired, 32'd8);
    check("trap_sticky", 32'(trap), 32'd1);
    rst = 1'b1;
    #1;
    check("trap_rst_flag", 32'(trap), 32'd0);
    check("trap_rst_pc", pc, 32'h0);
    check("trap_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // One instruction, then reset while stalled in FETCH at PC=4.
    imem_rdata = 32'h0010_0093;
    repeat (5) tick();
    check("mf_addr", imem_addr, 32'h4);
    imem_ack = 1'b0;
    tick();
    check("mf_state", 32'(state), 32'd1);
    rst = 1'b1;
    #1;
    check("mf_rst_state", 32'(state), 32'd0);
    check("mf_rst_pc", pc, 32'h0);
    check("mf_rst_req", 32'(imem_req), 32'd0);
    check("mf_rst_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the scalar RV32I core datapath.
- Fetches instructions from instruction memory over a req/ack handshake, classifies the opcode, and strobes register-file read, execute and register-file write in turn.
- Owns the PC and a retired-instruction counter; traps on unsupported opcodes.
- Sits between instruction memory and the core's register file / ALU datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential PC increment (byte addressing)

Ports:
CLOCK  in  1  core clock, rising edge
RESET  in  1  asynchronous, active-high reset
HALT  in  1  hold sequencer in IDLE before next fetch
IMEM_REQ  out  1  fetch request
IMEM_ADDR  out  32  fetch address (= PC)
IMEM_ACK  in  1  fetch accepted; data valid this cycle
IMEM_RDATA  in  32  fetched instruction word
INST  out  32  latched current instruction
RF_RD_EN  out  1  register-file read strobe (rs1/rs2 from INST)
EX_VALID  out  1  execute strobe to ALU/branch unit
BR_TAKEN  in  1  from branch unit, sampled while EX_VALID=1
BR_TARGET  in  32  branch/jump target, sampled with BR_TAKEN
RF_WE  out  1  register-file write enable
RF_WADDR  out  5  write register index (= INST[11:7])
PC  out  32  current program counter
RETIRED  out  32  retired-instruction count
TRAP  out  1  sticky illegal-opcode flag
STATE  out  3  debug: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, TRAPPED=5

Behaviour:
- Reset values (async, immediate): state IDLE; PC=RESET_PC; INST=0; RETIRED=0; TRAP=0; all strobes and IMEM_REQ = 0.
- IDLE: no outputs asserted. Goes to FETCH on the next edge when HALT=0; stays while HALT=1.
- FETCH:
  - IMEM_REQ=1; IMEM_ADDR=PC, held stable until ack.
  - On an edge with IMEM_ACK=1: INST<=IMEM_RDATA; go to DECODE.
  - With no ack, stay in FETCH indefinitely (no timeout).
  - HALT is ignored during FETCH.
- DECODE: RF_RD_EN=1 for exactly one cycle. Classify INST[6:0]:
  - 0010011 OP-IMM, 0110011 OP, 0110111 LUI: write-class.
  - 1100011 BRANCH: no write.
  - 1101111 JAL: write-class plus jump.
  - Any other opcode: go to TRAPPED; otherwise go to EXECUTE.
- EXECUTE: EX_VALID=1 for one cycle. For BRANCH/JAL, BR_TAKEN and BR_TARGET are registered on this edge. For other opcodes BR_TAKEN is ignored. Go to WRITEBACK.
- WRITEBACK:
  - RF_WE=1 iff the opcode is write-class and INST[11:7]≠0; RF_WADDR=INST[11:7] (valid whenever RF_WE=1).
  - On exit: PC<=BR_TARGET if (JAL) or (BRANCH and sampled BR_TAKEN=1); else PC<=PC+PC_STEP (mod 2^32, wraps 32'hFFFF_FFFC→0).
  - RETIRED<=RETIRED+1 (wraps at 2^32).
  - Next state: FETCH if HALT=0, else IDLE.
- TRAPPED:
  - TRAP=1; no strobes.
  - PC stays at the faulting instruction; RETIRED is not incremented.
  - Exited only by RESET.
- Minimum latency: 4 cycles per instruction with IMEM_ACK in the first FETCH cycle. Strobes are one-hot in time: at most one of IMEM_REQ/RF_RD_EN/EX_VALID/RF_WE is high in any cycle.
- Reset asserted mid-fetch or mid-writeback: the in-flight instruction is abandoned. No RF_WE pulse and no PC/RETIRED update after RESET rises.
- Outputs are registered or pure decodes of state/INST; no combinational path from inputs to outputs.

Test Plan:
- Reset, HALT=0, IMEM_ACK tied 1, IMEM_RDATA=32'h0010_0093 (addi x1,x0,1) → IMEM_ADDR 0,4,8 on every 4th cycle; RF_WE pulses with RF_WADDR=1; RETIRED=3 after 12 cycles.
- IMEM_ACK delayed 3 cycles → IMEM_REQ high for 4 cycles with IMEM_ADDR constant; INST updates only on the ack edge; RETIRED increments once.
- BRANCH 32'h0000_0063 with BR_TAKEN=1, BR_TARGET=32'h100 → next IMEM_ADDR=32'h100, no RF_WE. Repeat with BR_TAKEN=0 → next IMEM_ADDR=PC+4.
- JAL with rd=x0 (32'h0000_006F) and BR_TARGET=32'h40 → RF_WE stays 0; PC=32'h40.
- Illegal opcode 32'h0000_0000 → TRAP=1, STATE=5, IMEM_REQ stays 0, PC unchanged, RETIRED unchanged. Assert RESET → TRAP=0, PC=RESET_PC.
- HALT=1 during EXECUTE → WRITEBACK completes, then IDLE with IMEM_REQ=0. Deassert HALT → FETCH at the updated PC. RESET pulse mid-FETCH → immediately IDLE, PC=RESET_PC.
